// File: rtl/riscv_core_icache_refill_pkg.sv
// Shared types and constants for the instruction-cache line refill engine.
package riscv_core_icache_pkg;

  localparam int unsigned ICACHE_LINE_WIDTH     = 256;
  localparam int unsigned ICACHE_AXI_DATA_WIDTH = 64;
  localparam int unsigned ICACHE_BEATS_PER_LINE = ICACHE_LINE_WIDTH / ICACHE_AXI_DATA_WIDTH;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WRITE,
    ST_DONE
  } refill_state_e;

endpackage

// File: rtl/riscv_core_icache_line_assembler.sv
// Collects R-channel beats into a cache line. Beat k lands in slot
// (start + k) mod BEATS so a wrapping burst still yields a line in address order.
module riscv_core_icache_line_assembler
  import riscv_core_icache_pkg::*;
#(
  parameter  int unsigned AXI_DATA_WIDTH = ICACHE_AXI_DATA_WIDTH,
  parameter  int unsigned LINE_WIDTH     = ICACHE_LINE_WIDTH,
  localparam int unsigned BEATS          = LINE_WIDTH / AXI_DATA_WIDTH,
  localparam int unsigned SLOT_W         = $clog2(BEATS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [SLOT_W-1:0]         i_start_slot,
  input  logic                      i_beat_valid,
  input  logic [AXI_DATA_WIDTH-1:0] i_beat_data,
  output logic [SLOT_W-1:0]         o_beat_idx,
  output logic [LINE_WIDTH-1:0]     o_line
);

  logic [SLOT_W-1:0]     r_start;
  logic [SLOT_W-1:0]     r_cnt;
  logic [LINE_WIDTH-1:0] r_line;
  logic [SLOT_W-1:0]     w_slot;

  // BEATS is a power of two, so the narrow add wraps modulo BEATS for free
  assign w_slot     = r_start + r_cnt;
  assign o_beat_idx = r_cnt;
  assign o_line     = r_line;

  // Latch start slot on a new refill; store each accepted beat into its rotated slot
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start <= '0;
      r_cnt   <= '0;
      r_line  <= '0;
    end else if (i_start) begin
      r_start <= i_start_slot;
      r_cnt   <= '0;
    end else if (i_beat_valid) begin
      r_line[w_slot*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_beat_data;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_core_icache_refill.sv
// I-cache miss refill engine: one AXI read burst per miss, assembled line
// written to the cache in a single cycle, done/err pulse back to the core.
// Build option ICACHE_REFILL_CRITICAL_WORD_FIRST_EN: WRAP burst starting at the
// critical beat instead of an INCR burst from the line base.
module riscv_core_icache_refill
  import riscv_core_icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned AXI_DATA_WIDTH = ICACHE_AXI_DATA_WIDTH,
  parameter int unsigned LINE_WIDTH     = ICACHE_LINE_WIDTH,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_miss_req,
  input  logic [ADDR_WIDTH-1:0]     i_miss_addr,
  input  logic                      i_miss_offset,
  output logic                      o_refill_busy,
  output logic                      o_refill_done,
  output logic                      o_refill_err,
  output logic [LINE_WIDTH-1:0]     o_block_to_cache,
  output logic [ADDR_WIDTH-1:0]     o_addr_to_cache,
  output logic                      o_wr_en,
  output logic                      o_block_replace,
  output logic                      o_offset,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  localparam int unsigned BEATS    = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned SLOT_W   = $clog2(BEATS);
  localparam int unsigned BEAT_OFF = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned LINE_OFF = $clog2(LINE_WIDTH / 8);

  refill_state_e         r_state;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_araddr;
  logic [SLOT_W-1:0]     w_start_slot;
  logic [SLOT_W-1:0]     w_beat_idx;
  logic [1:0]            w_arburst;
  logic                  w_start;
  logic                  w_beat_fire;
  logic                  w_last_beat;
  logic                  w_beat_end;
  logic                  w_err_next;

  // Straddling fetch refills the line holding addr+2 (wraps modulo 2^ADDR_WIDTH)
  assign w_target = i_miss_offset ? i_miss_addr + ADDR_WIDTH'(2) : i_miss_addr;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign w_araddr     = (w_target >> BEAT_OFF) << BEAT_OFF;
  assign w_start_slot = w_target[BEAT_OFF +: SLOT_W];
  assign w_arburst    = AXI_BURST_WRAP;
`else
  assign w_araddr     = (w_target >> LINE_OFF) << LINE_OFF;
  assign w_start_slot = '0;
  assign w_arburst    = AXI_BURST_INCR;
`endif

  assign w_start     = (r_state == ST_IDLE) && i_miss_req;
  assign w_beat_fire = (r_state == ST_R) && i_rvalid && o_rready;
  assign w_last_beat = (w_beat_idx == SLOT_W'(BEATS - 1));
  assign w_beat_end  = w_beat_fire && (i_rlast || w_last_beat);
  // rlast must coincide exactly with the final beat; any mismatch is a protocol error
  assign w_err_next  = r_err || (i_rresp != AXI_RESP_OKAY) || (i_rlast != w_last_beat);

  riscv_core_icache_line_assembler #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .LINE_WIDTH     (LINE_WIDTH)
  ) u_line_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (w_start),
    .i_start_slot (w_start_slot),
    .i_beat_valid (w_beat_fire),
    .i_beat_data  (i_rdata),
    .o_beat_idx   (w_beat_idx),
    .o_line       (o_block_to_cache)
  );

  // Refill sequencer with all handshake and status outputs registered
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_err           <= 1'b0;
      o_refill_busy   <= 1'b0;
      o_refill_done   <= 1'b0;
      o_refill_err    <= 1'b0;
      o_addr_to_cache <= '0;
      o_wr_en         <= 1'b0;
      o_block_replace <= 1'b0;
      o_offset        <= 1'b0;
      o_arid          <= '0;
      o_araddr        <= '0;
      o_arlen         <= '0;
      o_arsize        <= '0;
      o_arburst       <= '0;
      o_arvalid       <= 1'b0;
      o_rready        <= 1'b0;
    end else begin
      o_refill_done   <= 1'b0;
      o_refill_err    <= 1'b0;
      o_wr_en         <= 1'b0;
      o_block_replace <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_miss_req) begin
            r_state         <= ST_AR;
            r_err           <= 1'b0;
            o_refill_busy   <= 1'b1;
            o_offset        <= i_miss_offset;
            o_addr_to_cache <= i_miss_addr;
            o_arid          <= '0;
            o_araddr        <= w_araddr;
            o_arlen         <= 8'(BEATS - 1);
            o_arsize        <= 3'(BEAT_OFF);
            o_arburst       <= w_arburst;
            o_arvalid       <= 1'b1;
          end
        end
        ST_AR: begin
          if (i_arready) begin
            r_state   <= ST_R;
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
          end
        end
        ST_R: begin
          if (w_beat_fire) begin
            r_err <= w_err_next;
            if (w_beat_end) begin
              o_rready <= 1'b0;
              if (w_err_next) begin
                r_state       <= ST_DONE;
                o_refill_done <= 1'b1;
                o_refill_err  <= 1'b1;
              end else begin
                r_state         <= ST_WRITE;
                o_wr_en         <= 1'b1;
                o_block_replace <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          r_state       <= ST_DONE;
          o_refill_done <= 1'b1;
          o_refill_err  <= r_err;
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          o_refill_busy <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_refill.sv
// Directed bench for riscv_core_icache_refill with an inline AXI slave and a
// scoreboard of expected cache writes and done/err pulses.
module tb_riscv_core_icache_refill;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_miss_req = 1'b0;
  logic [63:0]  i_miss_addr = '0;
  logic         i_miss_offset = 1'b0;
  logic         o_refill_busy, o_refill_done, o_refill_err;
  logic [255:0] o_block_to_cache;
  logic [63:0]  o_addr_to_cache;
  logic         o_wr_en, o_block_replace, o_offset;
  logic [3:0]   o_arid;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic         o_arvalid;
  logic         i_arready = 1'b0;
  logic [63:0]  i_rdata = '0;
  logic [1:0]   i_rresp = '0;
  logic         i_rlast = 1'b0;
  logic         i_rvalid = 1'b0;
  logic         o_rready;

  always #5 clk = ~clk;

  riscv_core_icache_refill #(
    .ADDR_WIDTH     (64),
    .AXI_DATA_WIDTH (64),
    .LINE_WIDTH     (256),
    .AXI_ID_WIDTH   (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_miss_req       (i_miss_req),
    .i_miss_addr      (i_miss_addr),
    .i_miss_offset    (i_miss_offset),
    .o_refill_busy    (o_refill_busy),
    .o_refill_done    (o_refill_done),
    .o_refill_err     (o_refill_err),
    .o_block_to_cache (o_block_to_cache),
    .o_addr_to_cache  (o_addr_to_cache),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_offset         (o_offset),
    .o_arid           (o_arid),
    .o_araddr         (o_araddr),
    .o_arlen          (o_arlen),
    .o_arsize         (o_arsize),
    .o_arburst        (o_arburst),
    .o_arvalid        (o_arvalid),
    .i_arready        (i_arready),
    .i_rdata          (i_rdata),
    .i_rresp          (i_rresp),
    .i_rlast          (i_rlast),
    .i_rvalid         (i_rvalid),
    .o_rready         (o_rready)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0]  addr;
    logic [255:0] line;
    logic         off;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  logic    done_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Backing memory: "simple" mode gives 0x11.., 0x22.., 0x33.., 0x44.. per line slot
  function automatic logic [63:0] mem_word(input logic [63:0] a, input logic simple);
    logic [7:0] b;
    b = 8'((a[4:3] + 1) * 17);
    return simple ? {8{b}} : {a[31:0] ^ 32'h5A3C_96E1, a[31:0]};
  endfunction

  function automatic logic [255:0] exp_line(input logic [63:0] t, input logic simple);
    logic [255:0] l;
    logic [63:0]  base;
    base = {t[63:5], 5'b0};
    for (int i = 0; i < 4; i++) l[64*i +: 64] = mem_word(base + 64'(8 * i), simple);
    return l;
  endfunction

  function automatic logic [63:0] exp_araddr(input logic [63:0] t);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return {t[63:3], 3'b0};
`else
    return {t[63:5], 5'b0};
`endif
  endfunction

  function automatic logic [1:0] exp_arburst();
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // Scoreboard consumer: every cache write and done pulse must match a queued expectation
  always @(negedge clk) begin
    wr_exp_t e;
    logic    d;
    if (rst_n) begin
      if (o_wr_en) begin
        if (wr_q.size() == 0) check("unexpected_wr", o_wr_en, 1'b0);
        else begin
          e = wr_q.pop_front();
          check("wr_line", o_block_to_cache, e.line);
          check("wr_addr", o_addr_to_cache, e.addr);
          check("wr_offset", o_offset, e.off);
          check("wr_replace", o_block_replace, 1'b1);
        end
      end
      if (o_refill_done) begin
        if (done_q.size() == 0) check("unexpected_done", o_refill_done, 1'b0);
        else begin
          d = done_q.pop_front();
          check("done_err", o_refill_err, d);
        end
      end
    end
  end

  // rlast_beat: beat index carrying rlast (4 = never asserted); resp_err_beat < 0 = none
  task automatic run_refill(input logic [63:0] addr, input logic off, input int ar_wait,
                            input int gap, input int resp_err_beat, input int rlast_beat,
                            input logic simple, input logic poke_req, input string tag);
    logic [63:0]  t, exp_ar, ar_cap, beat_addr;
    logic [1:0]   burst_cap;
    logic [255:0] line;
    logic         exp_err;
    logic         seen;
    int           last_k, c0;
    t       = addr + (off ? 64'd2 : 64'd0);
    line    = exp_line(t, simple);
    exp_err = (resp_err_beat >= 0) || (rlast_beat != 3);
    last_k  = (rlast_beat < 3) ? rlast_beat : 3;
    exp_ar  = exp_araddr(t);
    if (!exp_err) wr_q.push_back('{addr, line, off});
    done_q.push_back(exp_err);

    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = addr; i_miss_offset = off; c0 = cyc;
    @(posedge clk); #1;
    i_miss_req = 1'b0; i_miss_addr = '0; i_miss_offset = 1'b0;

    ar_cap = '0; burst_cap = '0;
    for (int w = 0; w <= ar_wait; w++) begin
      if (w == ar_wait) i_arready = 1'b1;
      @(negedge clk);
      check({tag, "_arvalid"}, o_arvalid, 1'b1);
      check({tag, "_araddr"}, o_araddr, exp_ar);
      check({tag, "_arlen"}, o_arlen, 8'd3);
      check({tag, "_arsize"}, o_arsize, 3'd3);
      check({tag, "_arburst"}, o_arburst, exp_arburst());
      check({tag, "_arid"}, o_arid, 4'd0);
      check({tag, "_busy"}, o_refill_busy, 1'b1);
      ar_cap = o_araddr; burst_cap = o_arburst;
      @(posedge clk); #1;
    end
    i_arready = 1'b0;

    for (int k = 0; k <= last_k; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (poke_req && k == 1) begin
          i_miss_req = 1'b1; i_miss_addr = 64'hDEAD_0000_0000_0000;
        end
        @(posedge clk); #1;
        i_miss_req = 1'b0; i_miss_addr = '0;
      end
      if (burst_cap == 2'b10) beat_addr = {ar_cap[63:5], 5'(ar_cap[4:0] + 5'(8 * k))};
      else beat_addr = ar_cap + 64'(8 * k);
      i_rvalid = 1'b1;
      i_rdata  = mem_word(beat_addr, simple);
      i_rresp  = (k == resp_err_beat) ? 2'b10 : 2'b00;
      i_rlast  = (k == rlast_beat);
      @(negedge clk);
      check({tag, "_rready"}, o_rready, 1'b1);
      @(posedge clk); #1;
      i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = '0; i_rdata = '0;
    end

    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (o_refill_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (!exp_err) check({tag, "_latency"}, cyc - c0, 7 + ar_wait + 4 * gap);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_busy"}, o_refill_busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_refill_busy, 1'b0);
    check({tag, "_done"}, o_refill_done, 1'b0);
    check({tag, "_err"}, o_refill_err, 1'b0);
    check({tag, "_line"}, o_block_to_cache, 256'd0);
    check({tag, "_addr"}, o_addr_to_cache, 64'd0);
    check({tag, "_wr_en"}, o_wr_en, 1'b0);
    check({tag, "_replace"}, o_block_replace, 1'b0);
    check({tag, "_offset"}, o_offset, 1'b0);
    check({tag, "_arvalid"}, o_arvalid, 1'b0);
    check({tag, "_araddr"}, o_araddr, 64'd0);
    check({tag, "_arlen"}, o_arlen, 8'd0);
    check({tag, "_arburst"}, o_arburst, 2'd0);
    check({tag, "_rready"}, o_rready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_refill(64'h0000_0000_1000_0044, 1'b0, 0, 0, -1, 3, 1'b1, 1'b0, "basic");
    run_refill(64'h0000_0000_1000_005E, 1'b1, 0, 0, -1, 3, 1'b0, 1'b0, "offset");
    run_refill(64'h0000_0000_2000_1238, 1'b0, 5, 2, -1, 3, 1'b0, 1'b1, "delay");
    run_refill(64'h0000_0000_3000_0000, 1'b0, 0, 0,  2, 3, 1'b0, 1'b0, "resp_err");
    run_refill(64'h0000_0000_3000_0020, 1'b0, 0, 0, -1, 3, 1'b0, 1'b0, "after_err");
    run_refill(64'h0000_0000_4000_0008, 1'b0, 0, 0, -1, 1, 1'b0, 1'b0, "early_rlast");
    run_refill(64'h0000_0000_4000_0028, 1'b0, 1, 1, -1, 4, 1'b0, 1'b0, "no_rlast");
    run_refill(64'h0000_0000_1000_0050, 1'b0, 0, 0, -1, 3, 1'b0, 1'b0, "wrap");
    run_refill(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0, 0, -1, 3, 1'b0, 1'b0, "addr_wrap");

    // Reset while two beats into a burst: everything clears, no write, no done
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 64'h0000_0000_5000_0100;
    @(posedge clk); #1;
    i_miss_req = 1'b0; i_miss_addr = '0; i_arready = 1'b1;
    @(posedge clk); #1;
    i_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_rvalid = 1'b1; i_rdata = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
      @(posedge clk); #1;
    end
    i_rvalid = 1'b0; i_rdata = '0;
    @(negedge clk);
    check("mid_r_busy", o_refill_busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_reset_busy", o_refill_busy, 1'b0);

    run_refill(64'h0000_0000_6000_0010, 1'b0, 0, 0, -1, 3, 1'b0, 1'b0, "post_reset");

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
